// File: rtl/m_mc_ctrl_if.sv
// Handshake bundle between the multi-cycle sequencer and the RV32I datapath.
// master = sequencer side, slave = datapath side.
interface m_mc_ctrl_if #(parameter int W_CNT = 32);
  logic             w_run;
  logic             w_r, w_i, w_s, w_b, w_u, w_j, w_ld;
  logic [4:0]       w_rd;
  logic             w_tkn;
  logic             w_mem_rdy;
  logic             w_imem_re;
  logic             w_ir_we;
  logic             w_pc_we;
  logic             w_pc_sel;
  logic             w_rf_we;
  logic             w_dmem_re;
  logic             w_dmem_we;
  logic             w_halt;
  logic [2:0]       w_state;
  logic [W_CNT-1:0] w_cycles;
  logic [W_CNT-1:0] w_instret;

  modport master (
    input  w_run, w_r, w_i, w_s, w_b, w_u, w_j, w_ld, w_rd, w_tkn, w_mem_rdy,
    output w_imem_re, w_ir_we, w_pc_we, w_pc_sel, w_rf_we, w_dmem_re, w_dmem_we,
           w_halt, w_state, w_cycles, w_instret
  );

  modport slave (
    output w_run, w_r, w_i, w_s, w_b, w_u, w_j, w_ld, w_rd, w_tkn, w_mem_rdy,
    input  w_imem_re, w_ir_we, w_pc_we, w_pc_sel, w_rf_we, w_dmem_re, w_dmem_we,
           w_halt, w_state, w_cycles, w_instret
  );
endinterface

// File: rtl/m_mc_ctrl.sv
// Five-step (IF/ID/EX/MEM/WB) sequencer gating PC/IR/RF/DMEM enables for RV32I.
// Define MC_CTRL_PERF_CNT_EN to build the active-cycle and retired-instruction counters.
module m_mc_ctrl #(
  parameter int W_CNT = 32
) (
  input logic          w_clk,
  input logic          w_rst,
  m_mc_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    IF   = 3'd1,
    ID   = 3'd2,
    EX   = 3'd3,
    MEM  = 3'd4,
    WB   = 3'd5,
    HALT = 3'd6
  } state_t;

  state_t state, nxt, ret;

  // R/I/U/J all take the default EX->WB path, so only their existence matters.
  logic unused_flags;
  assign unused_flags = ^{bus.w_r, bus.w_i, bus.w_u, bus.w_j};

  assign bus.w_state = state;

  always_comb begin
    ret           = bus.w_run ? IF : IDLE;
    nxt           = IDLE;
    bus.w_imem_re = 1'b0;
    bus.w_ir_we   = 1'b0;
    bus.w_pc_we   = 1'b0;
    bus.w_pc_sel  = 1'b0;
    bus.w_rf_we   = 1'b0;
    bus.w_dmem_re = 1'b0;
    bus.w_dmem_we = 1'b0;
    bus.w_halt    = 1'b0;
    case (state)
      IDLE: nxt = bus.w_run ? IF : IDLE;
      IF: begin
        bus.w_imem_re = 1'b1;
        bus.w_ir_we   = bus.w_mem_rdy;
        nxt           = bus.w_mem_rdy ? ID : IF;
      end
      ID: nxt = EX;
      EX: begin
        if (bus.w_b) begin
          bus.w_pc_we  = 1'b1;
          bus.w_pc_sel = bus.w_tkn;
          nxt          = ret;
        end else if (bus.w_s || bus.w_ld) begin
          nxt = MEM;
        end else begin
          nxt = WB;
        end
      end
      MEM: begin
        // Load wins if both flags ever show up, keeping the memory requests one-hot.
        bus.w_dmem_re = bus.w_ld;
        bus.w_dmem_we = bus.w_s && !bus.w_ld;
        if (!bus.w_mem_rdy) begin
          nxt = MEM;
        end else if (bus.w_ld) begin
          nxt = WB;
        end else begin
          bus.w_pc_we = 1'b1;
          nxt         = ret;
        end
      end
      WB: begin
        bus.w_rf_we = 1'b1;
        bus.w_pc_we = 1'b1;
        nxt         = (bus.w_rd == 5'd30) ? HALT : ret;
      end
      HALT: begin
        bus.w_halt = 1'b1;
        nxt        = HALT;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) state <= IDLE;
    else       state <= nxt;
  end

`ifdef MC_CTRL_PERF_CNT_EN
  logic [W_CNT-1:0] cycles, instret;

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      cycles  <= '0;
      instret <= '0;
    end else begin
      if (state != IDLE && state != HALT) cycles <= cycles + W_CNT'(1);
      if (bus.w_pc_we)                    instret <= instret + W_CNT'(1);
    end
  end

  assign bus.w_cycles  = cycles;
  assign bus.w_instret = instret;
`else
  assign bus.w_cycles  = '0;
  assign bus.w_instret = '0;
`endif

endmodule

// File: doc/m_mc_ctrl.md
# m_mc_ctrl

Multi-cycle sequencing controller for the RV32I datapath. It turns the single-cycle processor into a five-step machine (fetch, decode, execute, memory, write-back) so that instruction and data memories can have variable latency. It drives the write enables for PC, IR, register file and data memory from decoded instruction-type flags and a memory-ready handshake. It sits beside the datapath, replacing the free-running `r_pc <= w_pcin` update with gated, state-driven enables.

## Interface
Parameters:
- `W_CNT`, default 32: width of the performance counters.

Ports:
- `w_clk`  in  1  clock, rising edge.
- `w_rst`  in  1  reset, asynchronous, active-high.
- `w_run`  in  1  run enable; sampled only at instruction boundaries.
- `w_r, w_i, w_s, w_b, w_u, w_j, w_ld`  in  1 each  type flags decoded from the latched IR.
- `w_rd`  in  5  rd field of the latched IR.
- `w_tkn`  in  1  ALU branch-taken result.
- `w_mem_rdy`  in  1  the current memory access (fetch or data) completes this cycle.
- `w_imem_re`  out  1  instruction fetch request.
- `w_ir_we`  out  1  latch the fetched word into IR.
- `w_pc_we`  out  1  update PC at this edge.
- `w_pc_sel`  out  1  PC source: 1 = branch target, 0 = PC+4.
- `w_rf_we`  out  1  register-file write.
- `w_dmem_re`  out  1  data load request.
- `w_dmem_we`  out  1  data store request.
- `w_halt`  out  1  sticky halt flag.
- `w_state`  out  3  current state encoding.
- `w_cycles`  out  W_CNT  active-cycle counter.
- `w_instret`  out  W_CNT  retired-instruction counter.

## Operation
- States and encodings: IDLE=0, IF=1, ID=2, EX=3, MEM=4, WB=5, HALT=6. Codes 7 and above are illegal and go to IDLE on the next edge.
- IDLE: all enables 0. If `w_run`=1, go to IF.
- IF: `w_imem_re`=1 and held until `w_mem_rdy`. In the cycle with `w_mem_rdy`=1, `w_ir_we`=1 and the next state is ID.
- ID: one cycle for register-file read. Next state is EX.
- EX: one cycle for the ALU.
  - If `w_b`: `w_pc_we`=1, `w_pc_sel`=`w_tkn`, and the instruction retires.
  - If `w_s` or `w_ld`: go to MEM.
  - Otherwise: go to WB.
- MEM: `w_dmem_re`=`w_ld` and `w_dmem_we`=`w_s`, both held until `w_mem_rdy`. Repeated store cycles are idempotent.
  - Store with `w_mem_rdy`: `w_pc_we`=1 and the instruction retires.
  - Load with `w_mem_rdy`: go to WB.
- WB: `w_rf_we`=1 and `w_pc_we`=1 with `w_pc_sel`=0, and the instruction retires. If `w_rd`=30, go to HALT.
- Retire (EX branch, MEM store, WB): next state is IF if `w_run`=1, otherwise IDLE.
- HALT: `w_halt`=1 and all enables 0. Only `w_rst` leaves this state; `w_run` is ignored.
- `w_run` dropping mid-instruction does not abort the instruction. It completes, and the FSM then parks in IDLE.
- `w_pc_sel` is 0 in every cycle other than an EX branch.
- At most one of `w_imem_re`, `w_dmem_re`, `w_dmem_we` is high in any cycle.

## Timing
- All enables are combinational from `w_state` and the inputs within the same cycle. State updates on the rising edge of `w_clk`.
- Reset (asynchronous, immediate, mid-access included):
  - State returns to IDLE.
  - All enables, `w_halt`, `w_state` and both counters are 0.
  - A pending memory request is dropped.
- Latency with `w_mem_rdy` tied to 1:
  - ALU/U/J/I types: 4 cycles.
  - Branch: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- Each cycle with `w_mem_rdy` low adds exactly one cycle. There is no timeout.
- `w_pc_we` pulses exactly once per instruction.
- `w_rf_we` is never high for a branch or store.

## Configuration
- Macro `MC_CTRL_PERF_CNT_EN`.
- Defined:
  - `w_cycles` increments on every edge where the state is not IDLE or HALT.
  - `w_instret` increments on every `w_pc_we` cycle.
  - Both are W_CNT bits, wrap modulo 2^W_CNT and clear on reset.
- Undefined: both outputs are tied to 0 and no counter flops are built.

## Test plan
- Reset mid-MEM: load in MEM with `w_mem_rdy`=0, assert `w_rst` between edges -> `w_state`=0 and `w_dmem_re`=0 immediately; after release with `w_run`=1, IF is reached on the next edge.
- Register op: `w_r`=1, `w_rd`=5, `w_mem_rdy`=1 -> states 1,2,3,5; `w_rf_we` for 1 cycle in WB; one `w_pc_we`; with the macro, `w_instret`=1 and `w_cycles`=4.
- Slow load: `w_ld`=1, `w_mem_rdy` low for 3 MEM cycles -> `w_dmem_re` high for 4 cycles, then WB; 8 cycles total.
- Branch: `w_b`=1, `w_tkn`=1 -> `w_pc_we`=1 and `w_pc_sel`=1 in EX; `w_rf_we` never asserted; back to IF after 3 cycles. Repeat with `w_tkn`=0 -> `w_pc_sel`=0.
- Store, then `w_run` drops during ID -> `w_dmem_we` high only in MEM; the instruction retires; state goes to IDLE, not IF.
- Halt: I-type with `w_rd`=30 -> WB asserts `w_rf_we`, then state 6 with `w_halt`=1 held across 10 cycles despite `w_run`=1; counters frozen.
